// File: rtl/fifo_rd_scheduler.sv
// Round-robin burst read scheduler over NUM_SRC source FIFOs with downstream credit flow
// control, a read-latency tag pipeline that merges returned data, and sticky error flags.
module fifo_rd_scheduler #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 36,
    parameter int RD_LATENCY = 11,
    parameter int CREDITS    = 16,
    parameter int BURST_MAX  = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_SRC-1:0]              src_empty,
    output logic [NUM_SRC-1:0]              src_rd_en,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_rd_data,
    input  logic [NUM_SRC-1:0]              src_rd_valid,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [$clog2(NUM_SRC)-1:0]      out_src,
    output logic                            out_valid,
    input  logic                            credit_return,
    output logic [7:0]                      credit_avail,
    output logic [1:0]                      err
);
    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int BLK_W = 6;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   g_q, g_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [7:0]         credit_q, credit_d;
    logic [1:0]         err_q, err_d;
    logic [BLK_W-1:0]   blank_q, blank_d;
    logic [RD_LATENCY-1:0] tag_v_q, tag_v_d;
    logic [SRC_W-1:0]   tag_idx_q [RD_LATENCY];
    logic [SRC_W-1:0]   tag_idx_d [RD_LATENCY];

    logic               issue_s;
    logic               any_avail_s;
    logic [SRC_W-1:0]   g_next_s;
    logic [NUM_SRC-1:0] exp_valid_s;

    function automatic logic [SRC_W-1:0] rr_pick(input logic [NUM_SRC-1:0] empty,
                                                 input logic [SRC_W-1:0]   start);
        logic [SRC_W-1:0] pick;
        logic             found;
        logic [SRC_W:0]   idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = {1'b0, start} + (SRC_W+1)'(k);
            if (idx >= (SRC_W+1)'(NUM_SRC)) begin
                idx = idx - (SRC_W+1)'(NUM_SRC);
            end else begin
                idx = idx;
            end
            if (!found && !empty[idx[SRC_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[SRC_W-1:0];
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    function automatic logic [NUM_SRC-1:0] onehot(input logic [SRC_W-1:0] idx);
        logic [NUM_SRC-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign any_avail_s = |(~src_empty);
    assign issue_s     = (state_q == ST_GRANT) && !src_empty[g_q] && (credit_q != 8'd0);
    assign g_next_s    = (g_q == SRC_W'(NUM_SRC - 1)) ? '0 : g_q + SRC_W'(1);

    // Read enable goes straight out of the registered grant so a read can issue every cycle.
    always_comb begin
        src_rd_en = '0;
        if (issue_s) begin
            src_rd_en[g_q] = 1'b1;
        end else begin
            src_rd_en = '0;
        end
    end

    // Grant FSM: pick next source in IDLE, burst-read in GRANT until limit or source drains.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if ((credit_q != 8'd0) && any_avail_s) begin
                    g_d     = rr_pick(src_empty, ptr_q);
                    cnt_d   = 8'd0;
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (issue_s) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'(BURST_MAX - 1)) begin
                        state_d = ST_IDLE;
                        ptr_d   = g_next_s;
                    end else begin
                        state_d = ST_GRANT;
                    end
                end else if (src_empty[g_q]) begin
                    state_d = ST_IDLE;
                    ptr_d   = g_next_s;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Credit accounting; a return with the pool already full is dropped and flagged.
    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        if (issue_s && !credit_return) begin
            credit_d = credit_q - 8'd1;
        end else if (!issue_s && credit_return) begin
            if (credit_q == 8'(CREDITS)) begin
                err_d[1] = 1'b1;
            end else begin
                credit_d = credit_q + 8'd1;
            end
        end else begin
            credit_d = credit_q;
        end
        exp_valid_s = out_valid ? onehot(out_src) : '0;
        if ((blank_q == '0) && (src_rd_valid != exp_valid_s)) begin
            err_d[0] = 1'b1;
        end else begin
            err_d[0] = err_q[0];
        end
    end

    // After reset, reads launched before reset may still return; hold off the valid check.
    always_comb begin
        if (blank_q != '0) begin
            blank_d = blank_q - BLK_W'(1);
        end else begin
            blank_d = blank_q;
        end
    end

    // Tag pipeline shifts every cycle and mirrors the source FIFO read latency.
    always_comb begin
        tag_v_d[0]   = issue_s;
        tag_idx_d[0] = issue_s ? g_q : '0;
        for (int i = 1; i < RD_LATENCY; i++) begin
            tag_v_d[i]   = tag_v_q[i-1];
            tag_idx_d[i] = tag_idx_q[i-1];
        end
    end

    assign out_valid    = tag_v_q[RD_LATENCY-1];
    assign out_src      = tag_idx_q[RD_LATENCY-1];
    assign credit_avail = credit_q;
    assign err          = err_q;

    // Merge mux: select the returning source's slice, zero when nothing is returning.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (out_valid && (out_src == SRC_W'(i))) begin
                out_data = src_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                out_data = out_data;
            end
        end
    end

    // State, credit, error and tag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            g_q      <= '0;
            ptr_q    <= '0;
            cnt_q    <= 8'd0;
            credit_q <= 8'(CREDITS);
            err_q    <= 2'b00;
            blank_q  <= BLK_W'(RD_LATENCY);
            tag_v_q  <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_idx_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            credit_q  <= credit_d;
            err_q     <= err_d;
            blank_q   <= blank_d;
            tag_v_q   <= tag_v_d;
            tag_idx_q <= tag_idx_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_scheduler.sv
// Scoreboard bench for fifo_rd_scheduler: modelled source FIFOs with fixed read latency,
// expected words queued at read issue and compared when the merged output appears.
module tb_fifo_rd_scheduler;
    localparam int NS  = 4;
    localparam int DW  = 36;
    localparam int LAT = 11;
    localparam int CR  = 16;
    localparam int BM  = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NS-1:0]        src_empty;
    logic [NS-1:0]        src_rd_en;
    logic [NS*DW-1:0]     src_rd_data;
    logic [NS-1:0]        src_rd_valid;
    logic [DW-1:0]        out_data;
    logic [1:0]           out_src;
    logic                 out_valid;
    logic                 credit_return = 1'b0;
    logic [7:0]           credit_avail;
    logic [1:0]           err;

    int unsigned pushed [NS] = '{default: 0};
    int unsigned rd_cnt [NS] = '{default: 0};
    logic          dv [LAT] = '{default: 1'b0};
    logic [1:0]    ds [LAT] = '{default: 2'd0};
    logic [DW-1:0] dd [LAT] = '{default: '0};
    logic [NS-1:0] inj = '0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int          due;
        logic [1:0]  src;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb [$];

    fifo_rd_scheduler #(
        .NUM_SRC(NS), .DATA_WIDTH(DW), .RD_LATENCY(LAT), .CREDITS(CR), .BURST_MAX(BM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .src_empty(src_empty), .src_rd_en(src_rd_en),
        .src_rd_data(src_rd_data), .src_rd_valid(src_rd_valid), .out_data(out_data),
        .out_src(out_src), .out_valid(out_valid), .credit_return(credit_return),
        .credit_avail(credit_avail), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word(input int i, input int unsigned k);
        return {4'(i), k};
    endfunction

    function automatic logic [1:0] enc(input logic [NS-1:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < NS; i++) if (v[i]) r = 2'(i);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_issue(output logic [NS-1:0] v);
        int n;
        n = 0;
        while (src_rd_en == '0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("issue_seen", 64'(src_rd_en != '0), 64'd1);
        v = src_rd_en;
    endtask

    // Source FIFO model: empty flags from word counts, data returned LAT cycles after a read.
    always_comb begin
        for (int i = 0; i < NS; i++) begin
            src_empty[i] = (pushed[i] == rd_cnt[i]);
            src_rd_data[i*DW +: DW] = (dv[LAT-1] && ds[LAT-1] == 2'(i)) ? dd[LAT-1]
                                      : {4'hA, 30'h0, 2'(i)};
        end
        src_rd_valid = inj;
        if (dv[LAT-1]) src_rd_valid[ds[LAT-1]] = 1'b1;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NS; i++) if (src_rd_en[i]) rd_cnt[i] <= rd_cnt[i] + 1;
        dv[0] <= |src_rd_en;
        ds[0] <= enc(src_rd_en);
        dd[0] <= word(int'(enc(src_rd_en)), rd_cnt[enc(src_rd_en)]);
        for (int s = 1; s < LAT; s++) begin
            dv[s] <= dv[s-1];
            ds[s] <= ds[s-1];
            dd[s] <= dd[s-1];
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (src_rd_en != '0) begin
                check("rd_en_onehot", 64'($onehot(src_rd_en)), 64'd1);
                sb.push_back('{due: cyc + LAT, src: enc(src_rd_en),
                               data: word(int'(enc(src_rd_en)), rd_cnt[enc(src_rd_en)])});
            end
            if (out_valid) begin
                check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_src", 64'(out_src), 64'(e.src));
                    check("out_data", 64'(out_data), 64'(e.data));
                    check("out_latency", 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NS-1:0] v;
        logic [NS-1:0] seq [$];

        cycles(2);
        check("rst_rd_en", 64'(src_rd_en), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_src", 64'(out_src), 64'd0);
        check("rst_credit", 64'(credit_avail), 64'd16);
        check("rst_err", 64'(err), 64'd0);
        #2 rst_n = 1'b1;
        cycles(2);

        // single source: src2 holds three words
        pushed[2] += 3;
        #1 check("single_idle_no_read", 64'(src_rd_en), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("single_rd_en", 64'(src_rd_en), 64'h4);
        end
        @(negedge clk);
        check("single_rd_en_done", 64'(src_rd_en), 64'd0);
        cycles(15);
        check("single_credit", 64'(credit_avail), 64'd13);

        // pointer now at 3: src3 must win over src1
        pushed[1] += 1;
        pushed[3] += 1;
        wait_issue(v);
        check("rr_first_src3", 64'(v), 64'h8);
        @(negedge clk);
        wait_issue(v);
        check("rr_then_src1", 64'(v), 64'h2);
        cycles(15);
        check("rr_credit", 64'(credit_avail), 64'd11);

        // credit returns up to full, then an overflowing return
        credit_return = 1'b1;
        cycles(5);
        credit_return = 1'b0;
        check("ret_credit_full", 64'(credit_avail), 64'd16);
        check("ret_err_clear", 64'(err), 64'd0);
        credit_return = 1'b1;
        cycles(1);
        credit_return = 1'b0;
        check("ovf_err", 64'(err), 64'h2);
        check("ovf_credit", 64'(credit_avail), 64'd16);
        cycles(3);
        check("ovf_err_sticky", 64'(err), 64'h2);
        #2 rst_n = 1'b0;
        #1 check("rst2_err", 64'(err), 64'd0);
        cycles(2);
        #2 rst_n = 1'b1;
        cycles(2);

        // drain six credits via src3, leaving pointer at 0 and credit at 10
        pushed[3] += 6;
        cycles(25);
        check("pre_full_credit", 64'(credit_avail), 64'd10);

        // all sources full, no returns: 8 from src0, 2 from src1, then stall
        for (int i = 0; i < NS; i++) pushed[i] += 20;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (src_rd_en != '0) seq.push_back(src_rd_en);
        end
        check("full_issue_count", 64'(seq.size()), 64'd10);
        for (int k = 0; k < 10 && k < seq.size(); k++) begin
            check("full_issue_order", 64'(seq[k]), (k < 8) ? 64'h1 : 64'h2);
        end
        check("stall_credit", 64'(credit_avail), 64'd0);
        check("stall_rd_en", 64'(src_rd_en), 64'd0);

        // returns every cycle with continuous issue: credit holds, no stall
        credit_return = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("ret_issue_rd_en", 64'(src_rd_en), 64'h2);
            check("ret_issue_credit", 64'(credit_avail), 64'd1);
        end
        cycles(6);

        // reset mid-burst with reads in flight
        check("inflight_ge5", 64'(sb.size() >= 5), 64'd1);
        #2 rst_n = 1'b0;
        credit_return = 1'b0;
        #1;
        check("mid_rst_rd_en", 64'(src_rd_en), 64'd0);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_data", 64'(out_data), 64'd0);
        check("mid_rst_out_src", 64'(out_src), 64'd0);
        check("mid_rst_credit", 64'(credit_avail), 64'd16);
        for (int i = 0; i < NS; i++) pushed[i] = rd_cnt[i];
        cycles(2);
        #2 rst_n = 1'b1;
        for (int k = 0; k < LAT + 4; k++) begin
            @(negedge clk);
            check("post_rst_out_valid", 64'(out_valid), 64'd0);
            check("post_rst_err", 64'(err), 64'd0);
        end
        check("post_rst_credit", 64'(credit_avail), 64'd16);

        // read-data valid arriving one cycle early
        pushed[0] += 1;
        wait_issue(v);
        cycles(10);
        inj = 4'b0001;
        @(negedge clk);
        inj = 4'b0000;
        @(negedge clk);
        check("early_valid_err", 64'(err), 64'h1);
        cycles(5);
        check("early_valid_sticky", 64'(err), 64'h1);
        #2 rst_n = 1'b0;
        #1 check("early_rst_err", 64'(err), 64'd0);
        cycles(1);
        #2 rst_n = 1'b1;
        cycles(2);
        check("final_err", 64'(err), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_rd_scheduler.md
FIFO_RD_SCHEDULER -- requirements
Module: fifo_rd_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 4, meaning the number of source FIFO read ports (2..16).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 36, meaning the width of each FIFO data word.
REQ-003 The block SHALL have parameter RD_LATENCY, default 11, meaning the cycles from rd_en to rd_valid of each source FIFO (1..32).
REQ-004 The block SHALL have parameter CREDITS, default 16, meaning the downstream buffer depth in words (1..255).
REQ-005 The block SHALL have parameter BURST_MAX, default 8, meaning the maximum number of consecutive reads per grant (1..255).
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 The block SHALL have port src_empty, input, NUM_SRC bits: the empty flag of each source FIFO.
REQ-010 The block SHALL have port src_rd_en, output, NUM_SRC bits: the read enable to each source FIFO, one-hot or zero.
REQ-011 The block SHALL have port src_rd_data, input, NUM_SRC*DATA_WIDTH bits: the concatenated read data, with source i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 The block SHALL have port src_rd_valid, input, NUM_SRC bits: the read-data valid of each source FIFO.
REQ-013 The block SHALL have port out_data, output, DATA_WIDTH bits: the merged data word.
REQ-014 The block SHALL have port out_src, output, clog2(NUM_SRC) bits: the source index of out_data.
REQ-015 The block SHALL have port out_valid, output, 1 bit: out_data and out_src are valid.
REQ-016 The block SHALL have port credit_return, input, 1 bit: a one-cycle pulse meaning one downstream word has been consumed.
REQ-017 The block SHALL have port credit_avail, output, 8 bits: the current credit count.
REQ-018 The block SHALL have port err, output, 2 bits, sticky: bit0 is a latency or valid mismatch, bit1 is credit overflow.

Function
REQ-019 The block SHALL implement a registered FSM with states IDLE and GRANT, plus registers for grant index g, round-robin pointer ptr, and burst counter cnt.
REQ-020 In IDLE, when credit > 0 and any src_empty bit is 0, the block SHALL load g with the first non-empty index at or after ptr (modulo NUM_SRC), set cnt=0, and enter GRANT; no read is issued in that cycle.
REQ-021 In GRANT, issue = !src_empty[g] && credit > 0; src_rd_en[g] SHALL equal issue, derived combinationally from registered state and current inputs, with all other bits 0.
REQ-022 In GRANT, each issue SHALL increment cnt.
REQ-023 The block SHALL leave GRANT for IDLE with ptr = (g+1) mod NUM_SRC when it issues with cnt == BURST_MAX-1, or when src_empty[g] == 1.
REQ-024 In GRANT with credit == 0 and src_empty[g] == 0, the block SHALL stall: remain in GRANT with cnt held.
REQ-025 Credit update: credit_next = credit - issue + credit_return; a simultaneous issue and return SHALL leave credit unchanged.
REQ-026 A credit_return while credit == CREDITS with no issue in the same cycle SHALL be ignored and SHALL set err[1].
REQ-027 credit_avail SHALL be the registered credit value.
REQ-028 The tag pipeline SHALL be a RD_LATENCY-deep shift register of {issue, g}, shifting every cycle.
REQ-029 out_valid SHALL be the final-stage tag valid, out_src the final-stage tag index, and out_data = src_rd_data slice[out_src] when out_valid, else 0.
REQ-030 src_rd_en asserted in cycle t SHALL produce out_valid in cycle t+RD_LATENCY.
REQ-031 err[0] SHALL be set when src_rd_valid differs from onehot(out_src) gated by out_valid (expected all-zero when out_valid == 0).
REQ-032 Back-to-back issues SHALL yield back-to-back out_valid, one word per cycle maximum.
REQ-033 Round-robin fairness: no non-empty source SHALL wait more than (NUM_SRC-1)*(BURST_MAX+1) cycles for a grant while credit > 0.

Reset
REQ-034 rst_n low SHALL immediately force: state IDLE, ptr 0, g 0, cnt 0, credit CREDITS, all tag stages invalid, err 0.
REQ-035 While rst_n is low, outputs SHALL be src_rd_en 0, out_valid 0, out_data 0, out_src 0, and credit_avail CREDITS.
REQ-036 Reads in flight at reset SHALL be discarded; their later src_rd_valid SHALL NOT set err[0] within RD_LATENCY cycles after reset release.

Verification
REQ-037 Single source: NUM_SRC=4, src 2 holding 3 words, others empty -> IDLE to GRANT(g=2); src_rd_en=4'b0100 for 3 cycles; out_valid at t+11 with out_src=2 for 3 cycles; ptr=3.
REQ-038 All sources full, BURST_MAX=8, returns held 0 -> issue order 8 from src0, then 2 from src1, then stall with credit_avail=0 and src_rd_en=0.
REQ-039 credit_return pulsing every cycle with continuous issue -> credit_avail constant and no stall.
REQ-040 credit_return at credit=CREDITS -> err=2'b10 and credit_avail stays 16.
REQ-041 Inject src_rd_valid one cycle early (RD_LATENCY mismatch) -> err[0]=1 and sticky until reset.
REQ-042 Assert rst_n=0 mid-burst with 5 reads in flight -> outputs zero immediately; after release credit_avail=16, out_valid=0, and err=0.
